// File: rtl/pc_seq_pkg.sv
// Shared types and default widths for the fetch-stage PC sequencer.
// Build macro PC_SEQ_MISALIGN_TRAP_EN adds the TRAP state.
package pc_seq_pkg;

    localparam int PC_W_DEF    = 10;
    localparam int PC_STEP_DEF = 4;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_WAIT,
        ST_HALT
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        , ST_TRAP
`endif
    } pc_seq_state_t;

endpackage

// File: rtl/pc_seq_boot_cnt.sv
// Post-reset boot delay counter; done goes high on the last BOOT cycle.
module pc_seq_boot_cnt #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic done
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == CW'(CYCLES - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: boot delay, sequential fetch, branch redirect, stall, wait and halt.
// Build macro PC_SEQ_MISALIGN_TRAP_EN traps on branch targets not aligned to PC_STEP.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int PC_STEP     = PC_STEP_DEF,
    parameter int RESET_PC    = 0,
    parameter int BOOT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            is_Branch_Taken,
    input  logic [PC_W-1:0] branchPC,
    input  logic            halt_i,
    input  logic            resume_i,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    output logic            fetch_valid,
    output logic [PC_W-1:0] fetch_pc,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            trap_o
);

    localparam logic [PC_W-1:0] STEP     = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0] PC_RESET = PC_W'(RESET_PC);

    pc_seq_state_t   state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            flush_q, flush_d;
    logic            req_q;
    logic            boot_done;

    pc_seq_boot_cnt #(.CYCLES(BOOT_CYCLES)) u_boot_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == ST_BOOT),
        .done  (boot_done)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = 1'b0;

        case (state_q)
            ST_BOOT: begin
                if (boot_done) state_d = ST_FETCH;
            end
            ST_FETCH, ST_WAIT: begin
                if (is_Branch_Taken) begin
                    fetch_valid_d = 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
                    if ((32'(branchPC) % 32'(PC_STEP)) != 32'd0) begin
                        state_d = ST_TRAP;
                    end else begin
                        pc_d    = branchPC;
                        flush_d = 1'b1;
                    end
`else
                    pc_d    = branchPC;
                    flush_d = 1'b1;
`endif
                end else if (state_q == ST_WAIT) begin
                    if (imem_ready) begin
                        fetch_pc_d    = pc_q;
                        fetch_valid_d = 1'b1;
                        pc_d          = pc_q + STEP;
                        state_d       = ST_FETCH;
                    end
                end else if (halt_i) begin
                    state_d       = ST_HALT;
                    fetch_valid_d = 1'b0;
                end else if (stall_i) begin
                    state_d = ST_FETCH;
                end else if (!imem_ready) begin
                    state_d       = ST_WAIT;
                    fetch_valid_d = 1'b0;
                end else begin
                    // Sequential step; the wrap past the top of the address space is intentional.
                    fetch_pc_d    = pc_q;
                    fetch_valid_d = 1'b1;
                    pc_d          = pc_q + STEP;
                end
            end
            ST_HALT: begin
                fetch_valid_d = 1'b0;
                if (is_Branch_Taken) begin
                    pc_d    = branchPC;
                    flush_d = 1'b1;
                end
                if (resume_i) state_d = ST_FETCH;
            end
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            ST_TRAP: begin
                fetch_valid_d = 1'b0;
            end
`endif
            default: begin
                state_d       = ST_BOOT;
                fetch_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= PC_RESET;
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            req_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            req_q         <= (state_d == ST_FETCH) || (state_d == ST_WAIT);
        end
    end

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) trap_q <= 1'b0;
        else        trap_q <= (state_d == ST_TRAP);
    end

    assign trap_o = trap_q;
`else
    assign trap_o = 1'b0;
`endif

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign ifid_flush  = flush_q;
    assign ifid_en     = ((state_q == ST_FETCH) || (state_q == ST_WAIT)) && !stall_i;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expectations follow PC_SEQ_MISALIGN_TRAP_EN.
module tb_pc_sequencer;

    localparam int PC_W = 10;

    logic            clk;
    logic            reset;
    logic            stall_i;
    logic            is_Branch_Taken;
    logic [PC_W-1:0] branchPC;
    logic            halt_i;
    logic            resume_i;
    logic            imem_ready;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            fetch_valid;
    logic [PC_W-1:0] fetch_pc;
    logic            ifid_en;
    logic            ifid_flush;
    logic            trap_o;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .PC_W        (PC_W),
        .PC_STEP     (4),
        .RESET_PC    (0),
        .BOOT_CYCLES (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .is_Branch_Taken (is_Branch_Taken),
        .branchPC        (branchPC),
        .halt_i          (halt_i),
        .resume_i        (resume_i),
        .imem_ready      (imem_ready),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .trap_o          (trap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; stall_i = 1'b0; is_Branch_Taken = 1'b0; branchPC = '0;
        halt_i = 1'b0; resume_i = 1'b0; imem_ready = 1'b1;

        tick();
        check("rst_req",   32'(imem_req),    32'd0);
        check("rst_addr",  32'(imem_addr),   32'd0);
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_fpc",   32'(fetch_pc),    32'd0);
        check("rst_en",    32'(ifid_en),     32'd0);
        check("rst_flush", 32'(ifid_flush),  32'd0);
        check("rst_trap",  32'(trap_o),      32'd0);

        reset = 1'b1;
        tick();
        check("boot_e1_req", 32'(imem_req), 32'd0);
        tick();
        check("boot_e2_req",  32'(imem_req),  32'd1);
        check("boot_e2_addr", 32'(imem_addr), 32'd0);
        check("boot_e2_en",   32'(ifid_en),   32'd1);

        tick();
        check("seq0_fpc",   32'(fetch_pc),    32'h000);
        check("seq0_valid", 32'(fetch_valid), 32'd1);
        check("seq0_addr",  32'(imem_addr),   32'h004);
        tick();
        check("seq1_fpc", 32'(fetch_pc), 32'h004);
        tick();
        check("seq2_fpc", 32'(fetch_pc), 32'h008);
        tick();
        check("seq3_fpc",   32'(fetch_pc),    32'h00C);
        check("seq3_valid", 32'(fetch_valid), 32'd1);
        check("seq3_addr",  32'(imem_addr),   32'h010);

        // Branch taken with a simultaneous stall: the stall is ignored.
        is_Branch_Taken = 1'b1; branchPC = 10'h100; stall_i = 1'b1;
        #1;
        check("br_stall_en", 32'(ifid_en), 32'd0);
        tick();
        is_Branch_Taken = 1'b0; stall_i = 1'b0;
        check("br_addr",  32'(imem_addr),   32'h100);
        check("br_flush", 32'(ifid_flush),  32'd1);
        check("br_valid", 32'(fetch_valid), 32'd0);
        check("br_fpc",   32'(fetch_pc),    32'h00C);
        tick();
        check("br_flush_end", 32'(ifid_flush), 32'd0);
        check("br_next_fpc",  32'(fetch_pc),   32'h100);
        check("br_next_addr", 32'(imem_addr),  32'h104);

        // Three cycles of imem_ready low at PC 0x008.
        is_Branch_Taken = 1'b1; branchPC = 10'h008;
        tick();
        is_Branch_Taken = 1'b0;
        check("wait_setup_addr", 32'(imem_addr), 32'h008);
        imem_ready = 1'b0;
        tick();
        tick();
        tick();
        check("wait_addr",  32'(imem_addr),   32'h008);
        check("wait_valid", 32'(fetch_valid), 32'd0);
        check("wait_req",   32'(imem_req),    32'd1);
        check("wait_en",    32'(ifid_en),     32'd1);
        imem_ready = 1'b1;
        tick();
        check("wait_done_fpc",   32'(fetch_pc),    32'h008);
        check("wait_done_valid", 32'(fetch_valid), 32'd1);
        check("wait_done_addr",  32'(imem_addr),   32'h00C);
        tick();
        check("wait_fetch_fpc", 32'(fetch_pc), 32'h00C);

        // Silent wrap at the top of the address space.
        is_Branch_Taken = 1'b1; branchPC = 10'h3FC;
        tick();
        is_Branch_Taken = 1'b0;
        check("wrap_addr", 32'(imem_addr), 32'h3FC);
        tick();
        check("wrap_fpc",   32'(fetch_pc),    32'h3FC);
        check("wrap_next",  32'(imem_addr),   32'h000);
        check("wrap_valid", 32'(fetch_valid), 32'd1);
        tick();
        check("wrap_fpc2",   32'(fetch_pc),    32'h000);
        check("wrap_valid2", 32'(fetch_valid), 32'd1);

        // Halt at 0x020, branch while halted, then resume together with halt.
        is_Branch_Taken = 1'b1; branchPC = 10'h020;
        tick();
        is_Branch_Taken = 1'b0;
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        check("halt_req",   32'(imem_req),    32'd0);
        check("halt_valid", 32'(fetch_valid), 32'd0);
        check("halt_addr",  32'(imem_addr),   32'h020);
        check("halt_en",    32'(ifid_en),     32'd0);
        is_Branch_Taken = 1'b1; branchPC = 10'h040;
        tick();
        is_Branch_Taken = 1'b0;
        check("halt_br_flush", 32'(ifid_flush), 32'd1);
        check("halt_br_req",   32'(imem_req),   32'd0);
        check("halt_br_addr",  32'(imem_addr),  32'h040);
        tick();
        check("halt_stay_req",   32'(imem_req),   32'd0);
        check("halt_stay_flush", 32'(ifid_flush), 32'd0);
        resume_i = 1'b1; halt_i = 1'b1;
        tick();
        resume_i = 1'b0; halt_i = 1'b0;
        check("resume_req",  32'(imem_req),  32'd1);
        check("resume_addr", 32'(imem_addr), 32'h040);
        tick();
        check("resume_fpc",   32'(fetch_pc),    32'h040);
        check("resume_valid", 32'(fetch_valid), 32'd1);

        // Stall holds PC, fetch_pc and fetch_valid.
        stall_i = 1'b1;
        tick();
        check("stall_en",    32'(ifid_en),     32'd0);
        check("stall_fpc",   32'(fetch_pc),    32'h040);
        check("stall_addr",  32'(imem_addr),   32'h044);
        check("stall_valid", 32'(fetch_valid), 32'd1);
        stall_i = 1'b0;

        // Misaligned branch target.
        is_Branch_Taken = 1'b1; branchPC = 10'h102;
        tick();
        is_Branch_Taken = 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        check("mis_trap", 32'(trap_o),   32'd1);
        check("mis_req",  32'(imem_req), 32'd0);
        tick();
        tick();
        check("mis_trap_hold", 32'(trap_o),    32'd1);
        check("mis_req_hold",  32'(imem_req),  32'd0);
        check("mis_pc_hold",   32'(imem_addr), 32'h044);
`else
        check("mis_addr", 32'(imem_addr), 32'h102);
        check("mis_trap", 32'(trap_o),    32'd0);
        check("mis_req",  32'(imem_req),  32'd1);
`endif

        // Asynchronous reset mid-operation, then a fresh boot.
        reset = 1'b0;
        #1;
        check("mid_rst_req",   32'(imem_req),    32'd0);
        check("mid_rst_addr",  32'(imem_addr),   32'd0);
        check("mid_rst_valid", 32'(fetch_valid), 32'd0);
        check("mid_rst_trap",  32'(trap_o),      32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("reboot_e1_req", 32'(imem_req), 32'd0);
        tick();
        check("reboot_e2_req",  32'(imem_req),  32'd1);
        check("reboot_e2_addr", 32'(imem_addr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
